// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle rasteriser and the VGA adapter wrapper.
package rect_pkg;

    // Control FSM state encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Visible screen size, shared with the VGA adapter wrapper.
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_scan_counter.sv
// 2-D raster counter (cx fastest). The next-position outputs let the owner
// register a pixel for the position the counter is about to hold, so the
// output registers always describe the counter's current candidate.
module rect_scan_counter #(
    parameter int SIZE_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [SIZE_W-1:0] w_i,
    input  logic [SIZE_W-1:0] h_i,
    output logic [SIZE_W-1:0] nxt_cx_o,
    output logic [SIZE_W-1:0] nxt_cy_o,
    output logic              last_pix_o,
    output logic              on_border_o
);

    logic [SIZE_W-1:0] cx_q;
    logic [SIZE_W-1:0] cy_q;
    logic [SIZE_W-1:0] cx_d;
    logic [SIZE_W-1:0] cy_d;
    logic [SIZE_W-1:0] w_m1_s;
    logic [SIZE_W-1:0] h_m1_s;
    logic              last_col_s;

    assign w_m1_s = w_i - SIZE_W'(1);
    assign h_m1_s = h_i - SIZE_W'(1);

    // Next raster position, end-of-row/rectangle flags and border test of the next position.
    always_comb begin
        last_col_s = (cx_q == w_m1_s);
        last_pix_o = last_col_s && (cy_q == h_m1_s);
        cx_d       = cx_q;
        cy_d       = cy_q;
        if (clear_i) begin
            cx_d = {SIZE_W{1'b0}};
            cy_d = {SIZE_W{1'b0}};
        end else if (advance_i) begin
            if (last_col_s) begin
                cx_d = {SIZE_W{1'b0}};
                cy_d = cy_q + SIZE_W'(1);
            end else begin
                cx_d = cx_q + SIZE_W'(1);
                cy_d = cy_q;
            end
        end else begin
            cx_d = cx_q;
            cy_d = cy_q;
        end
        on_border_o = (cx_d == {SIZE_W{1'b0}}) || (cx_d == w_m1_s) ||
                      (cy_d == {SIZE_W{1'b0}}) || (cy_d == h_m1_s);
        nxt_cx_o    = cx_d;
        nxt_cy_o    = cy_d;
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cx_q <= {SIZE_W{1'b0}};
            cy_q <= {SIZE_W{1'b0}};
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/rect_drawer.sv
// Rectangle rasteriser: accepts one command, then emits clipped (and
// optionally outline-only) pixel writes in raster order with back-pressure.
module rect_drawer
    import rect_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int CLR_W    = 3,
    parameter int SIZE_W   = 6,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [SIZE_W-1:0] w,
    input  logic [SIZE_W-1:0] h,
    input  logic [CLR_W-1:0]  colour,
    input  logic              outline,
    input  logic              plot_ready,
    output logic              busy,
    output logic              done,
    output logic              plot,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [CLR_W-1:0]  colour_out
);

    // Screen limits at the widened sum width so overflow compares as off-screen.
    localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCREEN_H);

    state_e            state_q;
    logic [X_W-1:0]    x0_q;
    logic [Y_W-1:0]    y0_q;
    logic [SIZE_W-1:0] w_q;
    logic [SIZE_W-1:0] h_q;
    logic [CLR_W-1:0]  colour_q;
    logic              outline_q;
    logic              busy_q;
    logic              done_q;
    logic              plot_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [CLR_W-1:0]  colour_out_q;

    logic              clear_s;
    logic              advance_s;
    logic [SIZE_W-1:0] nxt_cx_s;
    logic [SIZE_W-1:0] nxt_cy_s;
    logic              last_pix_s;
    logic              on_border_s;
    logic [X_W:0]      sum_x_s;
    logic [Y_W:0]      sum_y_s;
    logic              vis_s;
    logic              zero_size_s;

    // Counters restart in LOAD; in DRAW they move whenever the current
    // candidate is invisible or the sink takes it.
    assign clear_s   = (state_q == LOAD);
    assign advance_s = (state_q == DRAW) && (!plot_q || plot_ready);

    rect_scan_counter #(
        .SIZE_W (SIZE_W)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear_s),
        .advance_i   (advance_s),
        .w_i         (w_q),
        .h_i         (h_q),
        .nxt_cx_o    (nxt_cx_s),
        .nxt_cy_o    (nxt_cy_s),
        .last_pix_o  (last_pix_s),
        .on_border_o (on_border_s)
    );

    // Screen coordinates and visibility of the candidate about to be presented.
    always_comb begin
        sum_x_s     = (X_W+1)'(x0_q) + (X_W+1)'(nxt_cx_s);
        sum_y_s     = (Y_W+1)'(y0_q) + (Y_W+1)'(nxt_cy_s);
        vis_s       = (sum_x_s < SCR_W_L) && (sum_y_s < SCR_H_L) &&
                      (!outline_q || on_border_s);
        zero_size_s = (w_q == {SIZE_W{1'b0}}) || (h_q == {SIZE_W{1'b0}});
    end

    // Control FSM with command latch and registered pixel/handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            x0_q         <= {X_W{1'b0}};
            y0_q         <= {Y_W{1'b0}};
            w_q          <= {SIZE_W{1'b0}};
            h_q          <= {SIZE_W{1'b0}};
            colour_q     <= {CLR_W{1'b0}};
            outline_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            x_q          <= {X_W{1'b0}};
            y_q          <= {Y_W{1'b0}};
            colour_out_q <= {CLR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    if (start) begin
                        x0_q      <= x0;
                        y0_q      <= y0;
                        w_q       <= w;
                        h_q       <= h;
                        colour_q  <= colour;
                        outline_q <= outline;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    colour_out_q <= colour_q;
                    if (zero_size_s) begin
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        // Present candidate (0,0) in the first DRAW cycle.
                        plot_q  <= vis_s;
                        x_q     <= sum_x_s[X_W-1:0];
                        y_q     <= sum_y_s[Y_W-1:0];
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (advance_s) begin
                        if (last_pix_s) begin
                            plot_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            plot_q <= vis_s;
                            x_q    <= sum_x_s[X_W-1:0];
                            y_q    <= sum_y_s[Y_W-1:0];
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = colour_out_q;

endmodule

// File: tb/tb_rect_drawer.sv
// Scoreboard bench for rect_drawer: commands push their expected pixel list
// and cell count; a negedge monitor pops and compares accepted pixels and
// checks cycle accounting at every done pulse.
module tb_rect_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [5:0] w;
    logic [5:0] h;
    logic [2:0] colour;
    logic       outline;
    logic       plot_ready;
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;

    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;
    bit rand_bit  = 1'b1;

    always #5 clk = ~clk;

    assign plot_ready = rdy_rand ? rand_bit : rdy_force;

    rect_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .colour     (colour),
        .outline    (outline),
        .plot_ready (plot_ready),
        .busy       (busy),
        .done       (done),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour_out (colour_out)
    );

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t pix_q[$];
    int   cells_q[$];
    pix_t exp_p;
    int   exp_cells;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every candidate of the w*h grid, visible if on screen
    // and (filled or on the border), in row-major order.
    task automatic push_cmd(input int ax, input int ay, input int aw, input int ah,
                            input int ac, input int ao);
        for (int cy = 0; cy < ah; cy++) begin
            for (int cx = 0; cx < aw; cx++) begin
                int  sx;
                int  sy;
                bit  border;
                pix_t p;
                sx     = ax + cx;
                sy     = ay + cy;
                border = (cx == 0) || (cx == aw - 1) || (cy == 0) || (cy == ah - 1);
                if (sx < 160 && sy < 120 && (ao == 0 || border)) begin
                    p.px = sx;
                    p.py = sy;
                    p.pc = ac;
                    pix_q.push_back(p);
                end
            end
        end
        cells_q.push_back(aw * ah);
    endtask

    // Present one command for exactly one edge (caller is at posedge+1).
    task automatic issue(input int ax, input int ay, input int aw, input int ah,
                         input int ac, input int ao);
        push_cmd(ax, ay, aw, ah, ac, ao);
        x0      = 8'(ax);
        y0      = 7'(ay);
        w       = 6'(aw);
        h       = 6'(ah);
        colour  = 3'(ac);
        outline = 1'(ao);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", (k >= 3000) ? 1 : 0, 0);
    endtask

    // Random sink readiness, refreshed every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_bit = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pixel scoreboard, stall stability and per-command cycle accounting.
    int busy_cyc   = 0;
    int stall_cyc  = 0;
    bit prev_stall = 1'b0;
    int prev_x     = 0;
    int prev_y     = 0;
    int prev_c     = 0;

    always @(negedge clk) begin
        if (!reset) begin
            busy_cyc   = 0;
            stall_cyc  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_plot", int'(plot), 1);
                check("hold_x", int'(x), prev_x);
                check("hold_y", int'(y), prev_y);
                check("hold_colour", int'(colour_out), prev_c);
            end
            if (busy) busy_cyc++;
            if (plot && !plot_ready) stall_cyc++;
            if (plot && plot_ready) begin
                if (pix_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    exp_p = pix_q.pop_front();
                    check("pix_x", int'(x), exp_p.px);
                    check("pix_y", int'(y), exp_p.py);
                    check("pix_colour", int'(colour_out), exp_p.pc);
                end
            end
            if (done) begin
                n_done++;
                check("done_busy_low", int'(busy), 0);
                if (cells_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_cells = cells_q.pop_front();
                    check("busy_cycles", busy_cyc - stall_cyc, 1 + exp_cells);
                    check("pixels_left", pix_q.size(), 0);
                end
                busy_cyc  = 0;
                stall_cyc = 0;
            end
            prev_stall = plot && !plot_ready;
            prev_x     = int'(x);
            prev_y     = int'(y);
            prev_c     = int'(colour_out);
        end
    end

    int nd0;

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        x0      = 8'd0;
        y0      = 7'd0;
        w       = 6'd0;
        h       = 6'd0;
        colour  = 3'd0;
        outline = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour_out), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Filled 3x2 with first-pixel latency.
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        issue(10, 20, 3, 2, 5, 0);
        check("lat_load_plot", int'(plot), 0);
        check("lat_load_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        check("lat_first_plot", int'(plot), 1);
        check("lat_first_x", int'(x), 10);
        check("lat_first_y", int'(y), 20);
        wait_idle();

        // Outline and clipping.
        issue(0, 0, 4, 4, 3, 1);
        wait_idle();
        issue(158, 118, 4, 4, 6, 0);
        wait_idle();
        issue(250, 125, 10, 6, 1, 0);
        wait_idle();

        // Back-pressure: first pixel stalled for 3 cycles.
        rdy_force = 1'b0;
        issue(30, 40, 2, 1, 7, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_plot", int'(plot), 1);
            check("bp_x", int'(x), 30);
            check("bp_y", int'(y), 40);
            if (i == 3) rdy_force = 1'b1;
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Zero size, with a second start while busy.
        nd0 = n_done;
        issue(5, 5, 0, 5, 2, 0);
        check("zero_load_busy", int'(busy), 1);
        check("zero_load_done", int'(done), 0);
        x0    = 8'd1;
        y0    = 7'd1;
        w     = 6'd1;
        h     = 6'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        check("zero_one_done", n_done, nd0 + 1);
        check("zero_idle", int'(busy), 0);

        // Randomised commands with random back-pressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 25; n++) begin
            issue($urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 9),
                  $urandom_range(0, 9), $urandom_range(0, 7), $urandom_range(0, 1));
            wait_idle();
        end
        rdy_rand = 1'b0;

        // Reset mid-draw of a 6x6 fill.
        rdy_force = 1'b1;
        issue(5, 5, 6, 6, 2, 0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b0;
        pix_q.delete();
        cells_q.delete();
        nd0 = n_done;
        @(posedge clk);
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_plot", int'(plot), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_done", int'(done), 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_done", n_done, nd0);
        issue(7, 9, 1, 1, 4, 0);
        wait_idle();
        check("post_rst_one_done", n_done, nd0 + 1);

        check("final_pix_queue", pix_q.size(), 0);
        check("final_cmd_queue", cells_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
